// File: rtl/seg_pkg.sv
// Shared constants, segment decode and FSM encoding for the seven-segment scan decoder.
package seg_pkg;

    localparam int unsigned NUM_DIGITS = 8;
    localparam int unsigned NIB_W      = 4;
    localparam int unsigned SEG_W      = 7;

    // Active-low gfedcba cathode codes as driven by the scan driver
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } seg_state_t;

    // Returns {valid, nibble}; valid=0 for blank and for any unknown pattern
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        case (seg)
            SEG_0:   return {1'b1, 4'h0};
            SEG_1:   return {1'b1, 4'h1};
            SEG_2:   return {1'b1, 4'h2};
            SEG_3:   return {1'b1, 4'h3};
            SEG_4:   return {1'b1, 4'h4};
            SEG_5:   return {1'b1, 4'h5};
            SEG_6:   return {1'b1, 4'h6};
            SEG_7:   return {1'b1, 4'h7};
            SEG_8:   return {1'b1, 4'h8};
            SEG_9:   return {1'b1, 4'h9};
            SEG_A:   return {1'b1, 4'hA};
            SEG_B:   return {1'b1, 4'hB};
            SEG_C:   return {1'b1, 4'hC};
            SEG_D:   return {1'b1, 4'hD};
            SEG_E:   return {1'b1, 4'hE};
            SEG_F:   return {1'b1, 4'hF};
            default: return 5'b0_0000;
        endcase
    endfunction

endpackage

// File: rtl/seg_scan_decoder_if.sv
// Display-pin inputs and decoded-word outputs of the scan decoder.
interface seg_scan_decoder_if;
    import seg_pkg::*;

    logic [NUM_DIGITS-1:0]       anodes;
    logic [7:0]                  cnodes;
    logic [NUM_DIGITS*NIB_W-1:0] data;
    logic [NUM_DIGITS-1:0]       dp_mask;
    logic                        frame_valid;
    logic                        data_changed;
    logic                        locked;
    logic                        err_seg;
    logic                        err_anode;
    logic                        timeout;

    // Side that drives the display pins and observes the decoded word
    modport master (
        output anodes, cnodes,
        input  data, dp_mask, frame_valid, data_changed, locked, err_seg, err_anode, timeout
    );

    // Decoder side
    modport slave (
        input  anodes, cnodes,
        output data, dp_mask, frame_valid, data_changed, locked, err_seg, err_anode, timeout
    );
endinterface

// File: rtl/seg_slot_filter.sv
// Debounces the {anodes,cnodes} sample and strobes once per stable slot.
module seg_slot_filter #(
    parameter int unsigned SETTLE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] anodes,
    input  logic [7:0] cnodes,
    output logic       accept_c,
    output logic [7:0] held_anodes,
    output logic [7:0] held_cnodes
);
    localparam int unsigned CNT_W = $clog2(SETTLE + 1);

    logic [15:0]      held;
    logic [CNT_W-1:0] cnt;
    logic             same_c;

    assign same_c      = ({anodes, cnodes} == held);
    assign accept_c    = same_c && (cnt == CNT_W'(SETTLE - 1));
    assign held_anodes = held[15:8];
    assign held_cnodes = held[7:0];

    // Reload on change, otherwise count identical samples up to SETTLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held <= 16'hFFFF;
            cnt  <= '0;
        end else if (!same_c) begin
            held <= {anodes, cnodes};
            cnt  <= CNT_W'(1);
        end else if (cnt < CNT_W'(SETTLE)) begin
            cnt  <= cnt + CNT_W'(1);
        end
    end
endmodule

// File: rtl/seg_scan_decoder.sv
// Reassembles the multiplexed seven-segment scan back into a 32-bit word.
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int unsigned SETTLE  = 4,
    parameter int unsigned TIMEOUT = 65536
) (
    input  logic                clk,
    input  logic                rst,
    seg_scan_decoder_if.slave   bus
);
    localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

    logic                             accept_c;
    logic [7:0]                       held_an;
    logic [7:0]                       held_cn;

    logic [NUM_DIGITS-1:0][NIB_W-1:0] shadow, shadow_nxt;
    logic [NUM_DIGITS-1:0]            shadow_dp, shadow_dp_nxt;
    logic [NUM_DIGITS-1:0]            seen, seen_nxt;
    logic [NUM_DIGITS-1:0][NIB_W-1:0] data_q;
    logic [NUM_DIGITS-1:0]            dp_q;
    logic                             frame_valid_q, data_changed_q;
    logic                             err_seg_q, err_anode_q, timeout_q;
    logic [IDLE_W-1:0]                idle;
    seg_state_t                       state;

    logic [7:0] an_low;
    logic [2:0] idx;
    logic [4:0] dec;
    logic       slot_valid_c, seg_err_c, an_err_c, frame_done_c, idle_hit_c;

    seg_slot_filter #(.SETTLE(SETTLE)) u_filter (
        .clk         (clk),
        .rst         (rst),
        .anodes      (bus.anodes),
        .cnodes      (bus.cnodes),
        .accept_c    (accept_c),
        .held_anodes (held_an),
        .held_cnodes (held_cn)
    );

    // Classify the accepted slot and form the shadow contents it would produce
    always_comb begin
        an_low        = ~held_an;
        idx           = 3'd0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (an_low[i]) idx = 3'(i);
        end
        dec           = seg_decode(held_cn[6:0]);
        slot_valid_c  = accept_c && $onehot(an_low) && dec[4];
        seg_err_c     = accept_c && $onehot(an_low) && !dec[4] && (held_cn[6:0] != SEG_BLANK);
        an_err_c      = accept_c && (an_low != 8'h00) && !$onehot(an_low);
        shadow_nxt    = shadow;
        shadow_dp_nxt = shadow_dp;
        seen_nxt      = seen;
        shadow_nxt[idx]    = dec[3:0];
        shadow_dp_nxt[idx] = ~held_cn[7];
        seen_nxt[idx]      = 1'b1;
        frame_done_c  = slot_valid_c && (seen_nxt == 8'hFF);
        idle_hit_c    = !slot_valid_c && (idle == IDLE_W'(TIMEOUT - 1));
    end

    // Shadow capture, frame commit, lock FSM and idle timeout
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow         <= '0;
            shadow_dp      <= '0;
            seen           <= '0;
            data_q         <= '0;
            dp_q           <= '0;
            frame_valid_q  <= 1'b0;
            data_changed_q <= 1'b0;
            err_seg_q      <= 1'b0;
            err_anode_q    <= 1'b0;
            timeout_q      <= 1'b0;
            idle           <= '0;
            state          <= ST_UNLOCKED;
        end else begin
            frame_valid_q  <= 1'b0;
            data_changed_q <= 1'b0;
            timeout_q      <= 1'b0;
            err_seg_q      <= seg_err_c;
            err_anode_q    <= an_err_c;
            if (slot_valid_c) begin
                shadow    <= shadow_nxt;
                shadow_dp <= shadow_dp_nxt;
                idle      <= '0;
                if (frame_done_c) begin
                    data_q         <= shadow_nxt;
                    dp_q           <= shadow_dp_nxt;
                    frame_valid_q  <= 1'b1;
                    data_changed_q <= (shadow_nxt != data_q);
                    seen           <= '0;
                    state          <= ST_LOCKED;
                end else begin
                    seen <= seen_nxt;
                end
            end else begin
                if (idle != IDLE_W'(TIMEOUT)) idle <= idle + IDLE_W'(1);
                if (idle_hit_c) begin
                    timeout_q <= 1'b1;
                    seen      <= '0;
                    state     <= ST_UNLOCKED;
                end
            end
        end
    end

    assign bus.data         = data_q;
    assign bus.dp_mask      = dp_q;
    assign bus.frame_valid  = frame_valid_q;
    assign bus.data_changed = data_changed_q;
    assign bus.locked       = (state == ST_LOCKED);
    assign bus.err_seg      = err_seg_q;
    assign bus.err_anode    = err_anode_q;
    assign bus.timeout      = timeout_q;
endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench: stimulus queues expected events, a monitor pops and compares.
module tb_seg_scan_decoder;
    localparam int K_FRAME = 1;
    localparam int K_SEG   = 2;
    localparam int K_ANODE = 3;
    localparam int K_TMO   = 4;

    typedef struct {
        int          kind;
        logic [31:0] d;
        logic [7:0]  dp;
        logic        ch;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   t_start = 0;
    int   last_acc = 0;
    exp_t q[$];

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    seg_scan_decoder_if bus ();

    seg_scan_decoder #(.SETTLE(4), .TIMEOUT(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input logic [31:0] d, input logic [7:0] dp,
                        input logic ch, input int c);
        exp_t e;
        e.kind = kind; e.d = d; e.dp = dp; e.ch = ch; e.cyc = c;
        q.push_back(e);
    endtask

    // Monitor side: pop one expectation per DUT event
    task automatic take(input int kind);
        exp_t e;
        if (q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d, expected none (cycle %0d)", kind, cyc);
        end else begin
            e = q.pop_front();
            chk("event_kind", 32'(kind), 32'(e.kind));
            if (kind == K_FRAME && e.kind == K_FRAME) begin
                chk("frame_data", bus.data, e.d);
                chk("frame_dp_mask", 32'(bus.dp_mask), 32'(e.dp));
                chk("frame_data_changed", 32'(bus.data_changed), 32'(e.ch));
                chk("frame_locked", 32'(bus.locked), 32'd1);
            end
            if (kind == K_TMO && e.kind == K_TMO) begin
                chk("timeout_cycle", 32'(cyc), 32'(e.cyc));
                chk("timeout_locked", 32'(bus.locked), 32'd0);
                chk("timeout_data_kept", bus.data, e.d);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.data_changed && !bus.frame_valid) chk("changed_without_frame", 32'd1, 32'd0);
            if (bus.frame_valid) take(K_FRAME);
            if (bus.err_seg)     take(K_SEG);
            if (bus.err_anode)   take(K_ANODE);
            if (bus.timeout)     take(K_TMO);
        end
    end

    task automatic drive(input logic [7:0] an, input logic [7:0] cn, input int n);
        @(negedge clk);
        bus.anodes = an;
        bus.cnodes = cn;
        t_start    = cyc;
        repeat (n) @(posedge clk);
    endtask

    task automatic scan_digit(input int i, input logic [31:0] w, input logic [7:0] dpm);
        logic [7:0] an;
        logic [3:0] nib;
        an  = 8'h01 << i;
        nib = w[4*i +: 4];
        drive(~an, {~dpm[i], seg_tab[nib]}, 8);
        last_acc = t_start + 4;
    endtask

    task automatic scan_word(input logic [31:0] w, input logic [7:0] dpm, input logic ch);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) push(K_FRAME, w, dpm, ch, -1);
            scan_digit(i, w, dpm);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_data"}, bus.data, 32'h0);
        chk({tag, "_dp_mask"}, 32'(bus.dp_mask), 32'h0);
        chk({tag, "_locked"}, 32'(bus.locked), 32'h0);
        chk({tag, "_pulses"}, 32'({bus.frame_valid, bus.data_changed, bus.err_seg,
                                   bus.err_anode, bus.timeout}), 32'h0);
    endtask

    initial begin
        bus.anodes = 8'hFF;
        bus.cnodes = 8'hFF;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // First frame locks and reports a change
        scan_word(32'h1234ABCD, 8'h00, 1'b1);
        @(negedge clk);
        chk("locked_after_first", 32'(bus.locked), 32'd1);

        // Identical frames: valid each time, never changed
        repeat (3) scan_word(32'h1234ABCD, 8'h00, 1'b0);

        // Short glitch and a blank-cathode slot are ignored
        for (int i = 0; i < 8; i++) begin
            if (i == 3) drive(8'hF7, {1'b1, seg_tab[5]}, 2);
            if (i == 5) drive(8'hDF, 8'hFF, 8);
            if (i == 7) push(K_FRAME, 32'hFEDC0987, 8'h81, 1'b1, -1);
            scan_digit(i, 32'hFEDC0987, 8'h81);
        end

        // Bad cathode on digit 3, then multi-anode slot; frame waits for a valid digit 3
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                push(K_SEG, 32'h0, 8'h0, 1'b0, -1);
                drive(8'hF7, 8'hFE, 8);
            end else begin
                scan_digit(i, 32'h13579BDF, 8'h00);
            end
        end
        push(K_ANODE, 32'h0, 8'h0, 1'b0, -1);
        drive(8'hFC, 8'hC0, 8);
        push(K_FRAME, 32'h13579BDF, 8'h00, 1'b1, -1);
        scan_digit(3, 32'h13579BDF, 8'h00);

        // Display goes dark: timeout 64 cycles after the last accept
        push(K_TMO, 32'h13579BDF, 8'h00, 1'b0, last_acc + 64);
        drive(8'hFF, 8'hFF, 75);
        chk("unlocked_after_timeout", 32'(bus.locked), 32'd0);
        chk("data_after_timeout", bus.data, 32'h13579BDF);

        // Reset mid-frame clears everything at once
        for (int i = 0; i < 5; i++) scan_digit(i, 32'hAAAAAAAA, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_all_zero("midreset");
        @(negedge clk);
        rst = 1'b0;
        scan_word(32'h000000FF, 8'h00, 1'b1);
        @(negedge clk);
        chk("final_data", bus.data, 32'h000000FF);
        chk("final_locked", 32'(bus.locked), 32'd1);

        repeat (10) @(negedge clk);
        chk("all_expected_events_seen", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/seg_scan_decoder.md
# seg_scan_decoder

Receive-side counterpart of the CPU board's seven-segment scan driver. It watches the multiplexed, active-low `anodes`/`cnodes` bus, debounces each digit slot, and decodes the cathode pattern back to a hex nibble. It reassembles the eight digits into the 32-bit word being displayed. It sits beside the `mips` top in benches and self-check harnesses, and turns `led_data` on the display pins into a checkable register value.

## Interface
- `SETTLE`, 4: consecutive identical samples required to accept a digit slot (≥2).
- `TIMEOUT`, 65536: cycles without an accepted slot before lock is dropped (≥SETTLE+8).
- `clk` in 1: system clock, same domain as the scan driver.
- `rst` in 1: reset, asynchronous, active-high.
- `anodes` in 8: digit enables, active-low; bit i selects digit i = nibble [4i+3:4i].
- `cnodes` in 8: cathodes, active-low; [7]=dp, [6:0]=g,f,e,d,c,b,a.
- `data` out 32: last completely captured word.
- `dp_mask` out 8: decimal-point state per digit, captured with `data` (1 = lit).
- `frame_valid` out 1: one-cycle pulse when `data` is updated.
- `data_changed` out 1: one-cycle pulse, coincident with `frame_valid`, when new `data` differs from old.
- `locked` out 1: a full frame has been seen and no timeout has occurred since.
- `err_seg` out 1: one-cycle pulse when an accepted slot carries an undecodable pattern.
- `err_anode` out 1: one-cycle pulse when a stable sample has more than one anode low.
- `timeout` out 1: one-cycle pulse when the timeout counter expires.

## Operation
- Holding register `{anodes,cnodes}` with a stability counter `cnt`:
  - sample differs from held: load held, `cnt`=1;
  - sample equal and `cnt`<SETTLE: increment `cnt`.
- Acceptance fires exactly once, on the edge where `cnt` goes SETTLE-1→SETTLE. It does not fire again until the sample changes.
- At acceptance, the held anodes are classified:
  - all ones (blank): ignored, no error;
  - one low bit i: decode `cnodes[6:0]`;
  - more than one low bit: `err_anode`, slot discarded.
- Decode, active-low gfedcba: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex).
  - Cathodes 7F (blank): ignored, no error.
  - Any other unmatched pattern: `err_seg`, slot discarded.
- Valid slot: write nibble into shadow[i], write ~cnodes[7] into shadow_dp[i], set seen[i]. Re-scanning digit i before the frame completes overwrites it.
- When the write makes seen == FF:
  - `data`/`dp_mask` load from shadow, including this slot;
  - `frame_valid` pulses, plus `data_changed` if `data` changed;
  - seen clears.
- FSM states UNLOCKED and LOCKED; `locked`=1 in LOCKED.
  - UNLOCKED→LOCKED on the first frame completion.
  - LOCKED→UNLOCKED on timeout.
  - Frame completions in LOCKED stay in LOCKED.
- Idle counter:
  - clears on every valid slot; otherwise saturating increment.
  - On reaching TIMEOUT-1→TIMEOUT: `timeout` pulse, seen clears, state→UNLOCKED. Fires once per idle period.
  - `data` holds its value through a timeout.
- Simultaneous frame completion and timeout are impossible: a valid slot clears the idle counter.

## Timing
- Reset values:
  - `data`=0, `dp_mask`=0, all pulses 0, `locked`=0;
  - held=FFFF, `cnt`=0, seen=0, idle counter=0, state UNLOCKED.
- Inputs are sampled directly; no synchronizer (same clock).
- Latency: input stable from edge n (first sampled at n) → accepted at edge n+SETTLE-1.
- A completing slot updates `data`/`frame_valid` registered at that same edge.
- A slot stable for fewer than SETTLE samples is never accepted.
- Async reset mid-frame discards shadow/seen immediately. The first frame after reset needs all eight digits.

## Structure
- Package `seg_pkg`:
  - segment code constants SEG_0..SEG_F and SEG_BLANK=7F;
  - function `seg_decode(input [6:0]) → {valid, nibble[3:0]}`;
  - FSM state localparams.
- Sub-module `seg_slot_filter`: holding register, `cnt`, `accept` strobe, and held anodes/cnodes outputs.
- Top: classification, shadow/seen, FSM, idle counter.

## Test plan
- Scan 32'h1234ABCD, digits 0→7, each held 8 cycles, SETTLE=4 → one `frame_valid` with `data_changed`, `data`=1234ABCD, `locked`=1, `dp_mask`=00.
- Re-scan same word three times → `frame_valid` each frame, `data_changed` never, `data` stable.
- Insert a 2-cycle glitch pattern between digits, plus one digit with cathodes 7F → no write, no error, frame completes when real digits arrive.
- Digit 3 with cathodes 7E → `err_seg` pulse, seen[3] stays 0, no `frame_valid` until digit 3 is shown validly. Anodes FC stable → `err_anode`.
- TIMEOUT=64, lock, then hold anodes FF → `timeout` pulse exactly 64 cycles after the last accept, `locked`=0, `data` retained.
- Assert `rst` after 5 of 8 digits → all outputs zero at once; a new full scan of 0000_00FF → `data`=000000FF.
